// File: rtl/vertical_strip_assembler.sv
// Vertical strip assembler: collects one HEIGHT-pixel column per beat, left to
// right, into a LENGTH-column binary frame. Once the frame is complete it is
// held for the downstream consumer. The frame is presented together with the
// leftmost non-blank column and flags for a blank frame, a short frame and an
// overrun.
module vertical_strip_assembler #(
  parameter int unsigned HEIGHT = 28,
  parameter int unsigned LENGTH = 28,
  parameter int unsigned COL_W  = $clog2(LENGTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           strip_valid,
  output logic                           strip_ready,
  input  logic [HEIGHT-1:0]              strip_data,
  input  logic                           strip_last,
  output logic [LENGTH-1:0][HEIGHT-1:0]  image,
  output logic                           image_valid,
  input  logic                           image_ready,
  output logic [COL_W-1:0]               first_col,
  output logic                           blank,
  output logic                           short_frame,
  output logic                           overrun
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(LENGTH - 1);

  typedef enum logic [1:0] {StFill, StHold, StClear} state_e;

  state_e                          state_q, state_d;
  logic [COL_W-1:0]                col_idx_q, col_idx_d;
  logic [LENGTH-1:0][HEIGHT-1:0]   image_q, image_d;
  logic [COL_W-1:0]                first_col_q, first_col_d;
  logic                            blank_q, blank_d;
  logic                            short_q, short_d;
  logic                            overrun_q, overrun_d;
  // Low through the reset cycle so strip_ready only rises on the first clock
  // after reset is released.
  logic                            started_q;

  logic accept;

  assign strip_ready = (state_q == StFill) && started_q;
  assign image_valid = (state_q == StHold);
  assign accept      = strip_valid && strip_ready;

  assign image       = image_q;
  assign first_col   = first_col_q;
  assign blank       = blank_q;
  assign short_frame = short_q;
  assign overrun     = overrun_q;

  // Next-state logic: column capture, leftmost-column tracking, frame handoff.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    image_d     = image_q;
    first_col_d = first_col_q;
    blank_d     = blank_q;
    short_d     = short_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          image_d[col_idx_q] = strip_data;
          // first_col latches once per frame, on the first non-zero column
          if (blank_q && (|strip_data)) begin
            first_col_d = col_idx_q;
            blank_d     = 1'b0;
          end
          if (col_idx_q == LastCol) begin
            state_d = StHold;
            if (!strip_last) overrun_d = 1'b1;
          end else if (strip_last) begin
            short_d = 1'b1;
            state_d = StHold;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (image_ready) state_d = StClear;
      end
      StClear: begin
        image_d     = '0;
        col_idx_d   = '0;
        first_col_d = '0;
        blank_d     = 1'b1;
        short_d     = 1'b0;
        state_d     = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  // State register; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      col_idx_q   <= '0;
      image_q     <= '0;
      first_col_q <= '0;
      blank_q     <= 1'b1;
      short_q     <= 1'b0;
      overrun_q   <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      image_q     <= image_d;
      first_col_q <= first_col_d;
      blank_q     <= blank_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
      started_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vertical_strip_assembler.sv
// Self-checking bench for vertical_strip_assembler: a table of frames with
// hand-computed results, plus directed sequences for the HOLD/CLEAR handshake
// and an asynchronous mid-frame reset.
module tb_vertical_strip_assembler;

  localparam int unsigned H = 28;
  localparam int unsigned L = 28;
  localparam int unsigned CW = $clog2(L);

  logic                 clk;
  logic                 rst;
  logic                 strip_valid;
  logic                 strip_ready;
  logic [H-1:0]         strip_data;
  logic                 strip_last;
  logic [L-1:0][H-1:0]  image;
  logic                 image_valid;
  logic                 image_ready;
  logic [CW-1:0]        first_col;
  logic                 blank;
  logic                 short_frame;
  logic                 overrun;

  int n_cmp = 0;
  int n_bad = 0;

  vertical_strip_assembler #(.HEIGHT(H), .LENGTH(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .strip_valid (strip_valid),
    .strip_ready (strip_ready),
    .strip_data  (strip_data),
    .strip_last  (strip_last),
    .image       (image),
    .image_valid (image_valid),
    .image_ready (image_ready),
    .first_col   (first_col),
    .blank       (blank),
    .short_frame (short_frame),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;      // strips in the frame
    bit          last;   // strip_last on the final strip
    int          ca;     // first hot column (-1 none)
    logic [H-1:0] da;
    int          cb;     // second hot column (-1 none)
    logic [H-1:0] db;
    int          first;
    bit          blank;
    bit          shortf;
    bit          ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one strip and hold it until accepted (bounded wait).
  task automatic send(input logic [H-1:0] d, input logic last);
    int n;
    n = 0;
    strip_valid = 1'b1;
    strip_data  = d;
    strip_last  = last;
    while (!strip_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!strip_ready) check("accept timeout", 64'(strip_ready), 64'd1);
    @(negedge clk);
    strip_valid = 1'b0;
    strip_last  = 1'b0;
    strip_data  = '0;
  endtask

  function automatic logic [H-1:0] col_val(input vec_t v, input int c);
    if (c >= v.n) return '0;
    if (c == v.ca) return v.da;
    if (c == v.cb) return v.db;
    return '0;
  endfunction

  // Take the held frame and check the CLEAR cycle and return to FILL.
  task automatic release_frame(input string tag);
    image_ready = 1'b1;
    @(negedge clk);
    image_ready = 1'b0;
    check({tag, " clear valid"}, 64'(image_valid), 64'd0);
    check({tag, " clear ready"}, 64'(strip_ready), 64'd0);
    @(negedge clk);
    check({tag, " fill ready"}, 64'(strip_ready), 64'd1);
    check({tag, " fill blank"}, 64'(blank), 64'd1);
    check({tag, " fill short"}, 64'(short_frame), 64'd0);
    check({tag, " fill image"}, 64'(image == '0), 64'd1);
  endtask

  initial begin
    vecs[0] = '{n: 28, last: 1, ca: 5, da: 28'h0000010, cb: 12, db: 28'h0000F00,
                first: 5, blank: 0, shortf: 0, ovr: 0};
    vecs[1] = '{n: 10, last: 1, ca: 9, da: 28'hFFFFFFF, cb: -1, db: '0,
                first: 9, blank: 0, shortf: 1, ovr: 0};
    vecs[2] = '{n: 28, last: 1, ca: -1, da: '0, cb: -1, db: '0,
                first: 0, blank: 1, shortf: 0, ovr: 0};
    vecs[3] = '{n: 28, last: 1, ca: 0, da: 28'h0000001, cb: 20, db: 28'h8000000,
                first: 0, blank: 0, shortf: 0, ovr: 0};
    vecs[4] = '{n: 28, last: 0, ca: 3, da: 28'h0000ABC, cb: -1, db: '0,
                first: 3, blank: 0, shortf: 0, ovr: 1};
    vecs[5] = '{n: 5, last: 1, ca: 4, da: 28'h0001000, cb: -1, db: '0,
                first: 4, blank: 0, shortf: 1, ovr: 1};

    strip_valid = 1'b0;
    strip_data  = '0;
    strip_last  = 1'b0;
    image_ready = 1'b0;
    rst         = 1'b1;

    #1;
    check("rst ready", 64'(strip_ready), 64'd0);
    check("rst valid", 64'(image_valid), 64'd0);
    check("rst blank", 64'(blank), 64'd1);
    check("rst first", 64'(first_col), 64'd0);
    check("rst short", 64'(short_frame), 64'd0);
    check("rst overrun", 64'(overrun), 64'd0);
    check("rst image", 64'(image == '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", 64'(strip_ready), 64'd1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        check($sformatf("v%0d valid during fill", i), 64'(image_valid), 64'd0);
        send(col_val(vecs[i], c), (c == vecs[i].n - 1) ? vecs[i].last : 1'b0);
      end
      check($sformatf("v%0d valid", i), 64'(image_valid), 64'd1);
      check($sformatf("v%0d ready in hold", i), 64'(strip_ready), 64'd0);
      check($sformatf("v%0d first_col", i), 64'(first_col), 64'(vecs[i].first));
      check($sformatf("v%0d blank", i), 64'(blank), 64'(vecs[i].blank));
      check($sformatf("v%0d short", i), 64'(short_frame), 64'(vecs[i].shortf));
      check($sformatf("v%0d overrun", i), 64'(overrun), 64'(vecs[i].ovr));
      for (int c = 0; c < L; c++)
        check($sformatf("v%0d img[%0d]", i, c), 64'(image[c]), 64'(col_val(vecs[i], c)));
      release_frame($sformatf("v%0d", i));
    end

    // Strip offered while in HOLD, together with image_ready
    for (int c = 0; c < L; c++)
      send((c == 2) ? 28'h00000FF : 28'h0, c == L - 1);
    check("hold valid", 64'(image_valid), 64'd1);
    check("hold img[2]", 64'(image[2]), 64'h00000FF);
    strip_valid = 1'b1;
    strip_data  = 28'h0000005;
    strip_last  = 1'b0;
    image_ready = 1'b1;
    check("hold ready w/ valid", 64'(strip_ready), 64'd0);
    @(negedge clk);
    image_ready = 1'b0;
    check("clear ready w/ valid", 64'(strip_ready), 64'd0);
    check("clear valid", 64'(image_valid), 64'd0);
    @(negedge clk);
    check("fill ready w/ valid", 64'(strip_ready), 64'd1);
    check("fill image cleared", 64'(image == '0), 64'd1);
    @(negedge clk);
    strip_valid = 1'b0;
    strip_data  = '0;
    check("held strip in col0", 64'(image[0]), 64'h0000005);
    check("old col2 cleared", 64'(image[2]), 64'h0);
    check("held strip first", 64'(first_col), 64'd0);
    check("held strip blank", 64'(blank), 64'd0);
    for (int c = 1; c < L; c++) send(28'h0, c == L - 1);
    check("held frame valid", 64'(image_valid), 64'd1);
    check("held frame col0", 64'(image[0]), 64'h0000005);
    check("held frame short", 64'(short_frame), 64'd0);
    release_frame("held");

    // Asynchronous reset mid-frame
    for (int c = 0; c < 7; c++) send(28'h0000033, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst image", 64'(image == '0), 64'd1);
    check("arst valid", 64'(image_valid), 64'd0);
    check("arst ready", 64'(strip_ready), 64'd0);
    check("arst blank", 64'(blank), 64'd1);
    check("arst overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < L; c++) send((c == 4) ? 28'h0000003 : 28'h0, c == L - 1);
    check("arst frame valid", 64'(image_valid), 64'd1);
    check("arst frame col4", 64'(image[4]), 64'h0000003);
    check("arst frame col0", 64'(image[0]), 64'h0);
    check("arst frame first", 64'(first_col), 64'd4);
    check("arst frame overrun", 64'(overrun), 64'd0);
    check("arst frame short", 64'(short_frame), 64'd0);
    release_frame("arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vertical_strip_assembler.md
Name: vertical_strip_assembler

Overview:
Builds a full binary image from a stream of vertical strips (one column of HEIGHT pixels per beat), filling columns left to right. When the frame is complete it presents the image to the feature-extraction and inference stages, together with the index of the leftmost non-blank column. It sits between the pixel-capture front end and the strip-extraction and classifier logic.

Parameters:
HEIGHT, 28, pixels per column (rows); overridden from global_params.vh
LENGTH, 28, columns per image; overridden from global_params.vh
COL_W, $clog2(LENGTH), width of column indices

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
strip_valid  input  1  strip_data is valid this cycle
strip_ready  output  1  block accepts a strip this cycle
strip_data  input  HEIGHT  one column; bit r = pixel in row r
strip_last  input  1  this strip is the final column of the frame
image  output  [LENGTH-1:0][HEIGHT-1:0]  assembled frame; image[c][r] = column c, row r
image_valid  output  1  image, first_col, blank and short_frame are stable and valid
image_ready  input  1  consumer takes the frame
first_col  output  COL_W  index of the leftmost column with any pixel set
blank  output  1  no pixel set in the whole frame
short_frame  output  1  strip_last arrived before column LENGTH-1
overrun  output  1  sticky; LENGTH columns were received without strip_last

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = FILL, col_idx = 0, image all zero.
  - image_valid = 0, strip_ready = 0 for the reset cycle, then 1 from the first clock after deassertion.
  - first_col = 0, blank = 1, short_frame = 0, overrun = 0.
- States:
  - FILL (strip_ready = 1, image_valid = 0)
  - HOLD (strip_ready = 0, image_valid = 1)
  - CLEAR (strip_ready = 0, image_valid = 0; one cycle)
- Accept condition: strip_valid && strip_ready. On accept, image[col_idx] <= strip_data.
- Leftmost column tracking:
  - On accept, if blank == 1 and |strip_data, then first_col <= col_idx and blank <= 0.
  - Once blank is 0, first_col is frozen for the frame.
- FILL transitions on accept:
  - strip_last && col_idx < LENGTH-1: short_frame <= 1; go to HOLD. Columns not written stay zero.
  - col_idx == LENGTH-1 (with or without strip_last): go to HOLD. If strip_last == 0, set overrun (sticky until reset).
  - Otherwise: col_idx <= col_idx + 1.
- Latency: image_valid rises the cycle after the final strip is accepted.
- HOLD:
  - All outputs are held stable.
  - strip_valid is ignored; no strip is accepted while in HOLD, even if image_ready is high in the same cycle.
  - On image_ready = 1: go to CLEAR.
- CLEAR:
  - image <= 0, col_idx <= 0, first_col <= 0, blank <= 1, short_frame <= 0.
  - Next state is FILL; strip_ready is 1 the cycle after CLEAR.
- Handshake rule: a strip presented during HOLD or CLEAR must be held by the producer until accepted; it is never dropped.
- col_idx never wraps past LENGTH-1; the transition to HOLD happens first.
- Reset mid-frame discards the partial frame; no image_valid is produced for it.

Test Plan:
- 28 strips, column 5 = 0x0000010, others zero, last on column 27 -> image_valid the cycle after the 28th accept; image[5] = 0x0000010; first_col = 5; blank = 0; short_frame = 0; overrun = 0.
- 10 strips, last on column 9, column 9 all ones -> HOLD after the 10th accept; image[9] = all ones; image[10..27] = 0; short_frame = 1; first_col = 9.
- 28 strips without strip_last -> HOLD after the 28th; overrun = 1 and stays 1 across the next frame until rst.
- In HOLD, strip_valid = 1 with image_ready = 1 in the same cycle -> strip_ready = 0 during HOLD and CLEAR; strip accepted on the first FILL cycle as column 0; previous frame's bits are cleared.
- All-zero frame -> blank = 1, first_col = 0; a second frame with column 0 nonzero -> first_col = 0, blank = 0.
- rst asserted asynchronously after 7 strips -> image = 0, col_idx = 0, image_valid = 0 immediately; the next frame assembles correctly from column 0.
